// File: rtl/ysyx_22050078_regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file: index/data widths and the zero word.
// Optional write-first bypass is selected by YSYX_22050078_REGFILE_BYPASS_EN (see top).
package ysyx_22050078_regfile_sb_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 64;
    localparam int RF_NR_RD      = 2;

    localparam logic [RF_DATA_WIDTH-1:0] ysyx_22050078_zero_word = '0;

endpackage

// File: rtl/ysyx_22050078_regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back or flush; masked lookups.
// Lookups are combinational; updates land on the next posedge; no backpressure.
module ysyx_22050078_regfile_scoreboard
    import ysyx_22050078_regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NR_LK      = RF_NR_RD + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        w_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic                        issue_en,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    input  logic [NR_LK*ADDR_WIDTH-1:0] lk_addr,
    output logic [NR_LK-1:0]            lk_busy
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clear before set so a same-cycle re-issue of the written register stays busy.
    always_comb begin
        busy_nxt = busy;
        if (w_en)
            busy_nxt[wr_addr] = 1'b0;
        if (issue_en)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // A write-back in flight this cycle already resolves the hazard it targets.
    for (genvar gi = 0; gi < NR_LK; gi++) begin : g_lk
        logic [ADDR_WIDTH-1:0] a;
        assign a = lk_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign lk_busy[gi] = busy[a] & ~(w_en && (wr_addr == a) && (wr_addr != '0));
    end

endmodule

// File: rtl/ysyx_22050078_regfile_sb.sv
// GPR file with NR_RD combinational read ports, one write-back port and a busy scoreboard.
// Read latency 0; write visible next cycle, or same cycle with YSYX_22050078_REGFILE_BYPASS_EN.
// No backpressure: the ID stage stalls on rs_busy / issue_rd_busy.
module ysyx_22050078_regfile_sb
    import ysyx_22050078_regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NR_RD      = RF_NR_RD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_RD*ADDR_WIDTH-1:0] rs_addr,
    output logic [NR_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NR_RD-1:0]            rs_busy,
    input  logic                        w_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        issue_en,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    output logic                        issue_rd_busy,
    input  logic                        flush
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = DATA_WIDTH'(ysyx_22050078_zero_word);

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NR_RD:0]        lk_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (w_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        assign a = rs_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef YSYX_22050078_REGFILE_BYPASS_EN
        logic hit;
        assign hit = w_en && (wr_addr == a) && (wr_addr != '0);
        assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = (a == '0) ? ZERO_WORD :
                                                      hit       ? wr_data   : regs[a];
`else
        assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = (a == '0) ? ZERO_WORD : regs[a];
`endif
    end

    // The last lookup port serves the issuing destination (WAW check).
    ysyx_22050078_regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_LK      (NR_RD + 1)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .w_en     (w_en),
        .wr_addr  (wr_addr),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .lk_addr  ({issue_rd, rs_addr}),
        .lk_busy  (lk_busy)
    );

    assign rs_busy       = lk_busy[NR_RD-1:0];
    assign issue_rd_busy = lk_busy[NR_RD];

endmodule

// File: tb/tb_ysyx_22050078_regfile_sb.sv
// Directed bench for the scoreboarded register file (default 5-bit index, 64-bit data, 2 ports).
module tb_ysyx_22050078_regfile_sb;

    logic         clk;
    logic         rst;
    logic [9:0]   rs_addr;
    logic [127:0] rd_data;
    logic [1:0]   rs_busy;
    logic         w_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         issue_en;
    logic [4:0]   issue_rd;
    logic         issue_rd_busy;
    logic         flush;

    int total = 0;
    int bad   = 0;

    ysyx_22050078_regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .rs_addr       (rs_addr),
        .rd_data       (rd_data),
        .rs_busy       (rs_busy),
        .w_en          (w_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .issue_en      (issue_en),
        .issue_rd      (issue_rd),
        .issue_rd_busy (issue_rd_busy),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge, return all controls to idle, then let inputs settle.
    task automatic next_cycle();
        @(negedge clk);
        rst = 1'b0; w_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    function automatic logic [63:0] rd0();
        return rd_data[63:0];
    endfunction

    function automatic logic [63:0] rd1();
        return rd_data[127:64];
    endfunction

    logic [63:0] hz_exp;

    initial begin
        rst = 1'b1; rs_addr = '0; w_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        next_cycle();
        rs_addr = {5'd0, 5'd5}; issue_rd = 5'd5; #1;
        chk("reset_rd_x5", rd0(), 64'h0);
        chk("reset_busy_x5", {63'h0, rs_busy[0]}, 64'h0);
        chk("reset_issue_busy", {63'h0, issue_rd_busy}, 64'h0);

        // Preload x5, then reset with conflicting writes/issues that must be ignored.
        w_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
        next_cycle(); rs_addr = {5'd0, 5'd5}; #1;
        chk("preload_x5", rd0(), 64'hDEAD);
        rst = 1'b1; w_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hBEEF;
        issue_en = 1'b1; issue_rd = 5'd5;
        next_cycle(); rs_addr = {5'd0, 5'd5}; #1;
        chk("post_rst_x5", rd0(), 64'h0);
        chk("post_rst_busy_x5", {63'h0, rs_busy[0]}, 64'h0);

        // x0 writes are discarded.
        w_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h1234; rs_addr = {5'd0, 5'd0}; #1;
        chk("x0_during_write", rd0(), 64'h0);
        next_cycle(); rs_addr = {5'd0, 5'd0}; #1;
        chk("x0_after_write", rd0(), 64'h0);

        // Plain write then dual-port read.
        w_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h0123_4567_89AB_CDEF;
        next_cycle(); rs_addr = {5'd7, 5'd7}; #1;
        chk("x7_port0", rd0(), 64'h0123_4567_89AB_CDEF);
        chk("x7_port1", rd1(), 64'h0123_4567_89AB_CDEF);

        // Same-cycle write/read of x3.
        w_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h11;
        next_cycle();
        w_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h22; rs_addr = {5'd7, 5'd3}; #1;
`ifdef YSYX_22050078_REGFILE_BYPASS_EN
        hz_exp = 64'h22;
`else
        hz_exp = 64'h11;
`endif
        chk("hazard_same_cycle", rd0(), hz_exp);
        next_cycle(); rs_addr = {5'd7, 5'd3}; #1;
        chk("hazard_next_cycle", rd0(), 64'h22);

        // Scoreboard: issue x9, observe busy, write-back masks then clears.
        issue_en = 1'b1; issue_rd = 5'd9; rs_addr = {5'd9, 5'd9}; #1;
        chk("x9_busy_issue_cycle", {63'h0, rs_busy[0]}, 64'h0);
        next_cycle(); rs_addr = {5'd9, 5'd9}; issue_rd = 5'd9; #1;
        chk("x9_busy_p0", {63'h0, rs_busy[0]}, 64'h1);
        chk("x9_busy_p1", {63'h0, rs_busy[1]}, 64'h1);
        chk("x9_issue_busy", {63'h0, issue_rd_busy}, 64'h1);
        w_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99; #1;
        chk("x9_masked_p0", {63'h0, rs_busy[0]}, 64'h0);
        chk("x9_masked_issue", {63'h0, issue_rd_busy}, 64'h0);
        next_cycle(); rs_addr = {5'd9, 5'd9}; issue_rd = 5'd9; #1;
        chk("x9_cleared", {62'h0, rs_busy}, 64'h0);
        chk("x9_data", rd0(), 64'h99);

        // Set beats clear on the same register.
        issue_en = 1'b1; issue_rd = 5'd4;
        next_cycle(); rs_addr = {5'd0, 5'd4}; #1;
        chk("x4_busy", {63'h0, rs_busy[0]}, 64'h1);
        w_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44; issue_en = 1'b1; issue_rd = 5'd4; #1;
        chk("x4_masked_same_cycle", {63'h0, rs_busy[0]}, 64'h0);
        next_cycle(); rs_addr = {5'd0, 5'd4}; issue_rd = 5'd4; #1;
        chk("x4_set_wins_rs", {63'h0, rs_busy[0]}, 64'h1);
        chk("x4_set_wins_issue", {63'h0, issue_rd_busy}, 64'h1);
        w_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h45;
        next_cycle(); rs_addr = {5'd0, 5'd4}; #1;
        chk("x4_cleared", {63'h0, rs_busy[0]}, 64'h0);

        // Issuing x0 never marks it busy.
        issue_en = 1'b1; issue_rd = 5'd0;
        next_cycle(); rs_addr = {5'd0, 5'd0}; issue_rd = 5'd0; #1;
        chk("x0_never_busy", {62'h0, rs_busy}, 64'h0);
        chk("x0_issue_busy", {63'h0, issue_rd_busy}, 64'h0);

        // Flush drops all busy bits and a simultaneous issue; data untouched.
        issue_en = 1'b1; issue_rd = 5'd1;
        next_cycle(); issue_en = 1'b1; issue_rd = 5'd2;
        next_cycle(); issue_en = 1'b1; issue_rd = 5'd31;
        next_cycle(); rs_addr = {5'd31, 5'd1}; issue_rd = 5'd2; #1;
        chk("pre_flush_x1", {63'h0, rs_busy[0]}, 64'h1);
        chk("pre_flush_x31", {63'h0, rs_busy[1]}, 64'h1);
        chk("pre_flush_x2", {63'h0, issue_rd_busy}, 64'h1);
        flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
        next_cycle(); rs_addr = {5'd31, 5'd1}; issue_rd = 5'd2; #1;
        chk("flush_x1_x31", {62'h0, rs_busy}, 64'h0);
        chk("flush_x2", {63'h0, issue_rd_busy}, 64'h0);
        issue_rd = 5'd6; rs_addr = {5'd3, 5'd7}; #1;
        chk("flush_x6_dropped", {63'h0, issue_rd_busy}, 64'h0);
        chk("flush_keeps_x7", rd0(), 64'h0123_4567_89AB_CDEF);
        chk("flush_keeps_x3", rd1(), 64'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050078_regfile_sb.md
Name: ysyx_22050078_regfile_sb

Overview:
- Parametrised successor to the single-cycle GPR file, for the pipelined NPC.
- Provides NR_RD read ports and one write-back port, plus synchronous reset of all registers.
- x0 hardwired to zero; optional write-to-read bypass.
- Integrated per-register busy scoreboard: decode/issue marks destinations busy and write-back clears them; busy flags drive RAW/WAW stall logic in the ID stage.

Parameters:
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register width in bits.
- NR_RD, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rs_addr  in  NR_RD*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NR_RD*DATA_WIDTH  packed read data, combinational.
- rs_busy  out  NR_RD  per-port scoreboard busy flag for the addressed register.
- w_en  in  1  write-back enable.
- wr_addr  in  ADDR_WIDTH  write-back destination.
- wr_data  in  DATA_WIDTH  write-back data.
- issue_en  in  1  an instruction writing issue_rd is issuing this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- issue_rd_busy  out  1  combinational; issue_rd is currently busy (WAW hazard indicator).
- flush  in  1  clear every busy bit (pipeline squash); registers keep their values.

Behaviour:
- Reset: on posedge clk with rst=1, all registers <= 0 and all busy bits <= 0; w_en, issue_en and flush are ignored that cycle.
- rd_data and rs_busy are combinational and valid in the cycle after reset deasserts.
- Write: on posedge clk, if w_en && wr_addr!=0, regs[wr_addr] <= wr_data. Writes to x0 are discarded.
- Read: rd_data port i = 0 when rs_addr i == 0, otherwise regs[rs_addr i]. Read latency is 0 cycles.
- Scoreboard update order per cycle, evaluated on posedge:
  - if rst, clear all;
  - else if flush, clear all (a simultaneous issue_en is dropped);
  - else clear busy[wr_addr] when w_en, then set busy[issue_rd] when issue_en.
  - Set wins when issue_rd==wr_addr in the same cycle.
- busy[0] is constantly 0; issue_en with issue_rd==0 has no effect.
- rs_busy i = busy[rs_addr i], except it reads 0 when w_en && wr_addr==rs_addr i && wr_addr!=0 (the write-back this cycle resolves the hazard).
- issue_rd_busy = busy[issue_rd] with the same write-back masking. The issuing stage must stall while it is 1; issuing onto a busy rd is illegal (single busy bit, no tags).
- Simultaneous write and read of the same register: see the Optional Feature.
- Illegal case: w_en on a non-busy register is legal (no scoreboard change).

Optional Feature:
- Macro YSYX_22050078_REGFILE_BYPASS_EN.
- Defined: when w_en && wr_addr!=0 && wr_addr==rs_addr i, rd_data i = wr_data in the same cycle (write-first).
- Undefined: rd_data i returns the pre-write value; the new value is visible from the next cycle (read-first).
- rs_busy masking is identical in both builds, so a non-bypass build requires the ID stage to hold one extra cycle after write-back (a pipeline-level concern, documented here).

Decomposition:
- Shared defines file holds ysyx_22050078_zero_word, ADDR_WIDTH/DATA_WIDTH defaults, and the bypass macro guard.
- One natural sub-module, ysyx_22050078_regfile_scoreboard: the busy-bit vector with set/clear/flush and masked lookup, instantiated once and exposing NR_RD+1 lookup ports.
- The data array and read muxing stay in the top module via a generate loop over NR_RD.

Test Plan:
- Reset: preload x5=0xDEAD via write, assert rst one cycle -> rs_addr0=5 reads 0, rs_busy=0; write x0=0x1234 -> read x0 returns 0.
- Read/write: write x7=0x0123_4567_89AB_CDEF, next cycle read x7 on both ports -> both return 0x0123_4567_89AB_CDEF.
- Same-cycle hazard: regs[3]=0x11; w_en with wr_addr=3, wr_data=0x22 while rs_addr0=3 -> rd_data0=0x22 with the bypass macro, 0x11 without; 0x22 the next cycle in both builds.
- Scoreboard: issue_en with rd=9 -> rs_busy=1 from the next cycle; write-back to x9 -> rs_busy masked to 0 that same cycle, busy bit cleared after the edge.
- Set beats clear: busy[4]=1; same cycle w_en wr_addr=4 and issue_en issue_rd=4 -> busy[4] stays 1; issue_rd_busy=1 for rd=4 the next cycle.
- Flush: busy x1, x2, x31; assert flush together with issue_en rd=6 -> all busy bits 0, including x6; register contents unchanged.
